// File: rtl/qsfp_hpd_conditioner.sv
// Turns the raw QSFP ModPrsL pin into a debounced, reset-sequenced hot-plug-detect.
// Optional forced replug (hpd drop while the module stays powered) is enabled by QSFP_HPD_REPLUG_EN.
module qsfp_hpd_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 200_000,
    parameter int unsigned RESET_CYCLES    = 2_000,
    parameter int unsigned INIT_CYCLES     = 400_000_000,
    parameter int unsigned REPLUG_CYCLES   = 40_000_000
) (
    input  logic       system_clock,
    input  logic       system_reset,
    input  logic       modprsl,
    input  logic       replug_request,
    output logic       resetl,
    output logic       hpd,
    output logic [1:0] state,
    output logic [7:0] insert_count
);

    localparam logic [31:0] DB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RESET_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] INIT_LAST   = 32'(INIT_CYCLES - 1);
    localparam logic [31:0] REPLUG_LAST = 32'(REPLUG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ABSENT = 3'd0,
        ST_RESET  = 3'd1,
        ST_INIT   = 3'd2,
        ST_READY  = 3'd3,
        ST_REPLUG = 3'd4
    } fsm_t;

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        present_db_q, present_db_d;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic [31:0] phase_q, phase_d;
    fsm_t        fsm_q, fsm_d;
    logic        resetl_q, resetl_d;
    logic        hpd_q, hpd_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  insert_count_q, insert_count_d;
    logic        present_raw;

`ifndef QSFP_HPD_REPLUG_EN
    logic unused_replug_request;
    assign unused_replug_request = replug_request;
`endif

    assign present_raw = ~sync2_q;

    always_comb begin
        sync1_d = modprsl;
        sync2_d = sync1_q;

        present_db_d = present_db_q;
        db_cnt_d     = 32'd0;
        if (present_raw != present_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                present_db_d = present_raw;
            end else begin
                db_cnt_d = db_cnt_q + 32'd1;
            end
        end

        fsm_d          = fsm_q;
        insert_count_d = insert_count_q;
        // Removal is checked first so it wins over any counter expiry or replug.
        if (!present_db_q) begin
            fsm_d = ST_ABSENT;
        end else begin
            case (fsm_q)
                ST_ABSENT: fsm_d = ST_RESET;
                ST_RESET:  if (phase_q == RESET_LAST) fsm_d = ST_INIT;
                ST_INIT: begin
                    if (phase_q == INIT_LAST) begin
                        fsm_d          = ST_READY;
                        insert_count_d = insert_count_q + 8'd1;
                    end
                end
`ifdef QSFP_HPD_REPLUG_EN
                ST_READY:  if (replug_request) fsm_d = ST_REPLUG;
                ST_REPLUG: if (phase_q == REPLUG_LAST) fsm_d = ST_READY;
`else
                ST_READY:  fsm_d = ST_READY;
`endif
                default:   fsm_d = ST_ABSENT;
            endcase
        end

        phase_d = phase_q;
        if (fsm_d != fsm_q) begin
            phase_d = 32'd0;
        end else if (fsm_q == ST_RESET || fsm_q == ST_INIT || fsm_q == ST_REPLUG) begin
            phase_d = phase_q + 32'd1;
        end

        // Outputs are decoded from the next state so they change on the same edge as the FSM.
        resetl_d = (fsm_d == ST_INIT) || (fsm_d == ST_READY) || (fsm_d == ST_REPLUG);
        hpd_d    = (fsm_d == ST_READY);
        state_d  = (fsm_d == ST_REPLUG) ? 2'd3 : fsm_d[1:0];
    end

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            present_db_q   <= 1'b0;
            db_cnt_q       <= 32'd0;
            phase_q        <= 32'd0;
            fsm_q          <= ST_ABSENT;
            resetl_q       <= 1'b0;
            hpd_q          <= 1'b0;
            state_q        <= 2'd0;
            insert_count_q <= 8'd0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            present_db_q   <= present_db_d;
            db_cnt_q       <= db_cnt_d;
            phase_q        <= phase_d;
            fsm_q          <= fsm_d;
            resetl_q       <= resetl_d;
            hpd_q          <= hpd_d;
            state_q        <= state_d;
            insert_count_q <= insert_count_d;
        end
    end

    assign resetl       = resetl_q;
    assign hpd          = hpd_q;
    assign state        = state_q;
    assign insert_count = insert_count_q;

endmodule

// File: tb/tb_qsfp_hpd_conditioner.sv
// Directed bench for qsfp_hpd_conditioner with small timing parameters (D=4, R=3, I=5, REPLUG=6).
module tb_qsfp_hpd_conditioner;

    logic       system_clock = 1'b0;
    logic       system_reset;
    logic       modprsl;
    logic       replug_request;
    logic       resetl;
    logic       hpd;
    logic [1:0] state;
    logic [7:0] insert_count;

    int n_tests = 0;
    int n_fail  = 0;

    qsfp_hpd_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .RESET_CYCLES   (3),
        .INIT_CYCLES    (5),
        .REPLUG_CYCLES  (6)
    ) dut (
        .system_clock  (system_clock),
        .system_reset  (system_reset),
        .modprsl       (modprsl),
        .replug_request(replug_request),
        .resetl        (resetl),
        .hpd           (hpd),
        .state         (state),
        .insert_count  (insert_count)
    );

    always #5 system_clock = ~system_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_tests++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_val);
        end
    endtask

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    // resetl is high exactly in INIT, READY and REPLUG, i.e. whenever the state code is 2 or 3.
    task automatic expect_out(input string tag, input int e, input int st, input int hp, input int ic);
        chk($sformatf("%s e%0d state", tag, e), 32'(state), 32'(st));
        chk($sformatf("%s e%0d resetl", tag, e), 32'(resetl), (st >= 2) ? 32'd1 : 32'd0);
        chk($sformatf("%s e%0d hpd", tag, e), 32'(hpd), 32'(hp));
        chk($sformatf("%s e%0d insert_count", tag, e), 32'(insert_count), 32'(ic));
    endtask

    task automatic do_reset();
        system_reset   = 1'b1;
        modprsl        = 1'b1;
        replug_request = 1'b0;
        tick();
        tick();
        system_reset = 1'b0;
    endtask

    // modprsl falls before edge 1: RESET at 7, INIT at 10, READY at 15. A replug pulse in INIT is ignored.
    task automatic run_insertion(input string tag);
        int st;
        modprsl = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            st = (e >= 15) ? 3 : (e >= 10) ? 2 : (e >= 7) ? 1 : 0;
            expect_out(tag, e, st, (e >= 15) ? 1 : 0, (e >= 15) ? 1 : 0);
            replug_request = (e == 10);
        end
        $display("[TB] %s done at edge 16", tag);
    endtask

    initial begin
        int st;
        int hp;

        system_reset   = 1'b1;
        modprsl        = 1'b1;
        replug_request = 1'b0;
        tick();
        tick();
        expect_out("reset", 0, 0, 0, 0);
        system_reset = 1'b0;
        $display("[TB] reset checked");

        run_insertion("insert");

        // Three synchronised low cycles is one short of the debounce window.
        do_reset();
        modprsl = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            expect_out("glitch", e, 0, 0, 0);
            if (e == 3) modprsl = 1'b1;
        end
        $display("[TB] glitch done");

        // Removal starting in RESET lands on edge 15, overriding INIT expiry.
        do_reset();
        modprsl = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            st = (e >= 15) ? 0 : (e >= 10) ? 2 : (e >= 7) ? 1 : 0;
            expect_out("removal", e, st, 0, 0);
            if (e == 8) modprsl = 1'b1;
        end
        $display("[TB] removal done");

        do_reset();
        run_insertion("replug_setup");
        replug_request = 1'b1;
        for (int e = 17; e <= 25; e++) begin
            tick();
            replug_request = (e == 19);
`ifdef QSFP_HPD_REPLUG_EN
            hp = (e >= 17 && e <= 22) ? 0 : 1;
`else
            hp = 1;
`endif
            expect_out("replug", e, 3, hp, 1);
        end
        $display("[TB] replug done");

        system_reset   = 1'b1;
        replug_request = 1'b0;
        tick();
        expect_out("mid_reset", 0, 0, 0, 0);
        system_reset = 1'b0;
        $display("[TB] mid-READY reset checked");
        run_insertion("reinsert");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
